iddmm_a_update: RTL and testbench
=================================

Name: iddmm_a_update

Overview:
- Accumulator-update engine for one outer iteration i of the iterative-digit Montgomery multiply (IDDMM).
- Consumes x_i and the quotient word q. Streams y[j], m[j] and a[j] from word memories.
- Computes a = (a + x_i*y + q*m) / 2^K and drives the wr_a_en/wr_a_addr/wr_a_data write stream, which the q-update stage consumes.
- Sits between the q-update block and the A word RAM.

Parameters:
- K, 128, bits per word.
- N, 32, number of words in the operand and modulus.
- ADDR_W, $clog2(N), word-index width. The A address is ADDR_W+1 bits because A holds N+1 words.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins an iteration
- x_i  in  K  multiplier word; latched on start
- q  in  K  quotient word from the q-update stage; latched on start
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse, coincident with the final write
- rd_addr  out  ADDR_W+1  word index for the y, m and a RAMs
- rd_y  in  K  y[rd_addr], returned 1 cycle after rd_addr
- rd_m  in  K  m[rd_addr], returned 1 cycle after rd_addr; 0 when rd_addr=N
- rd_a  in  K  a[rd_addr], returned 1 cycle after rd_addr
- wr_a_en  out  1  A write strobe
- wr_a_addr  out  ADDR_W+1  A write index, 0..N
- wr_a_data  out  K  A write data
- err  out  1  sticky check flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values: busy, done, wr_a_en, err = 0; rd_addr, wr_a_addr, wr_a_data = 0; carry and counters = 0; FSM in IDLE.
- rst_n low mid-operation aborts on the next edge. No further writes are issued.
- FSM states:
  - IDLE: start=1 latches x_i and q, clears carry, sets j=0, goes to RUN. Start is ignored in every other state.
  - RUN: issues rd_addr=j for j=0..N-1, one per cycle, then goes to TAIL.
  - TAIL: issues rd_addr=N. Goes to FLUSH when the last sum is registered.
  - FLUSH: emits the final write plus done, then returns to IDLE.
- Datapath: one cycle after rd_addr=j, form s_j = rd_a + x_i*rd_y + q*rd_m + c_{j-1} combinationally, and register it.
  - s_j is 2K+1 bits wide. The carry c_j = s_j[2K:K] is K+1 bits and feeds s_{j+1} on the next cycle (single-cycle loop).
  - For j=N, rd_y and rd_m are treated as 0, so s_N = a[N] + c_{N-1}.
- Writes, registered, occurring 2 cycles after the corresponding rd_addr:
  - j=0: no write. s_0[K-1:0] is zero by construction of q.
  - j=1..N: write wr_a_addr=j-1, data s_j[K-1:0].
  - One extra cycle: write wr_a_addr=N, data = zero-extended s_N[K] (only bit 0 is nonzero), with done=1.
- Timing, with start sampled at edge 0:
  - rd_addr=0 in cycle 1.
  - First write (addr 0) in cycle 4.
  - Write to addr N and done in cycle N+4.
  - busy spans cycles 1..N+4. Exactly N+1 writes per iteration, with strictly increasing addresses and no gaps.
- start arriving in the same cycle as done is ignored. The controller must wait for IDLE (busy=0).
- rd_addr holds its last value when not reading.

Optional Feature:
- IDDMM_A_CHECK_EN defined: on the j=0 sum, if s_0[K-1:0] != 0, set err=1. err is sticky until rst_n, and the write stream is unchanged.
- Not defined: no comparator is built and err is tied to 0.

Decomposition:
- Package iddmm_pkg holds:
  - constants IDDMM_K and IDDMM_N;
  - typedef word_t (logic [K-1:0]);
  - typedef carry_t (logic [K:0]);
  - FSM enum a_state_t {IDLE, RUN, TAIL, FLUSH}.
- One natural sub-module: iddmm_mac_2x, a combinational a + x*y + q*m + c producing 2K+1 bits. The FSM, counters, carry register and write pipeline stay in iddmm_a_update.

Test Plan:
- K=8, N=4, a=0, x_i=1, y=[1,0,0,0], m=[1,0,0,0], q=0xFF, start -> writes addr0..4 = 0x01,0x00,0x00,0x00,0x00; done in cycle 8; err=0.
- K=8, N=4, a=all 0xFF, x_i=0xFF, y=all 0xFF, m=all 0, q=0, start -> s_0=0xFF00. Carry propagation yields a[0..4] = 0xFF,0xFF,0xFF,0xFF,0x00; carry never exceeds K+1 bits.
- Same setup, start re-pulsed in cycles 2 and 8 (the done cycle) -> exactly 5 writes, a single done, no second iteration.
- rst_n low in cycle 5 of an N=4 run -> from the next cycle busy=0, wr_a_en=0, no done; a fresh start then completes normally.
- With IDDMM_A_CHECK_EN: x_i=1, y=[1,0,0,0], m=[1,0,0,0], q=0 -> s_0 low = 1, err=1 and held across a following clean iteration. Without the macro, err=0.
- Random K=128, N=32 run with back-to-back iterations (start in the cycle after done) versus a big-integer reference model -> bit-exact A; busy high for exactly N+4 cycles per iteration.

Source files
------------

// File: rtl/iddmm_pkg.sv
// Shared definitions for the IDDMM accumulator-update slice.
//   IDDMM_K / IDDMM_N : default word width and operand length in words
//   word_t / carry_t  : one operand word and one inter-word carry (K+1 bits)
//   a_state_t         : controller states of iddmm_a_update
package iddmm_pkg;
  localparam int IDDMM_K = 128;
  localparam int IDDMM_N = 32;

  typedef logic [IDDMM_K-1:0] word_t;
  typedef logic [IDDMM_K:0]   carry_t;

  typedef enum logic [1:0] {IDLE, RUN, TAIL, FLUSH} a_state_t;
endpackage

// File: rtl/iddmm_a_if.sv
// Bundle of the accumulator-update engine's control, RAM-read and A-write
// signals.
//   slave  : engine side (iddmm_a_update)
//   master : controller / RAM side
//
// Handshake semantics: there is no back-pressure anywhere. start is a one-cycle
// pulse honoured only while busy=0. Read data (rd_y/rd_m/rd_a) must be valid
// exactly one cycle after rd_addr. Every cycle with wr_a_en=1 is one accepted
// write of wr_a_data to wr_a_addr. done pulses together with the last write.
// dbg_state mirrors the controller state for observation.
interface iddmm_a_if
  import iddmm_pkg::*;
#(
  parameter int K      = IDDMM_K,
  parameter int N      = IDDMM_N,
  parameter int ADDR_W = $clog2(N)
) ();
  logic              start;
  logic [K-1:0]      x_i;
  logic [K-1:0]      q;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   rd_addr;
  logic [K-1:0]      rd_y;
  logic [K-1:0]      rd_m;
  logic [K-1:0]      rd_a;
  logic              wr_a_en;
  logic [ADDR_W:0]   wr_a_addr;
  logic [K-1:0]      wr_a_data;
  logic              err;
  a_state_t          dbg_state;

  modport slave (
    input  start, x_i, q, rd_y, rd_m, rd_a,
    output busy, done, rd_addr, wr_a_en, wr_a_addr, wr_a_data, err, dbg_state
  );

  modport master (
    output start, x_i, q, rd_y, rd_m, rd_a,
    input  busy, done, rd_addr, wr_a_en, wr_a_addr, wr_a_data, err, dbg_state
  );
endinterface

// File: rtl/iddmm_mac_2x.sv
// Combinational word multiply-accumulate: s = a + x*y + q*m + c.
//   a, x, y, q, m : K-bit words
//   c             : K+1-bit carry from the previous word
//   s             : 2K+1-bit sum; never overflows for any input values
module iddmm_mac_2x
  import iddmm_pkg::*;
#(
  parameter int K = IDDMM_K
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic [K-1:0] q,
  input  logic [K-1:0] m,
  input  logic [K:0]   c,
  output logic [2*K:0] s
);
  localparam int SW = 2 * K + 1;

  assign s = SW'(a) + SW'(x) * SW'(y) + SW'(q) * SW'(m) + SW'(c);
endmodule

// File: rtl/iddmm_a_update.sv
// One outer IDDMM iteration: A <= (A + x_i*Y + q*M) / 2^K, streamed word by
// word. Reads y/m/a at rd_addr = 0..N (one per cycle), forms one word sum per
// cycle with a single-cycle carry loop and writes A words 0..N back.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : iddmm_a_if slave (start/x_i/q in, busy/done out, RAM read
//                address and data, A write stream, err, dbg_state)
// Optional build macro IDDMM_A_CHECK_EN: flags (sticky err) a nonzero low
// word of the j=0 sum, which a correct quotient q always cancels.
module iddmm_a_update
  import iddmm_pkg::*;
#(
  parameter int K      = IDDMM_K,
  parameter int N      = IDDMM_N,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic     clk,
  input  logic     rst_n,
  iddmm_a_if.slave bus
);
  localparam int AW = ADDR_W + 1;
  localparam int SW = 2 * K + 1;
  typedef logic [AW-1:0] addr_t;
  localparam addr_t LAST_J = addr_t'(N - 1);
  localparam addr_t LAST_A = addr_t'(N);

  a_state_t       state, state_n;
  logic [K-1:0]   x_r, q_r;
  logic [K:0]     carry_r;
  addr_t          rd_addr_r;
  addr_t          d_idx;       // word index whose read data is on rd_* now
  logic           d_act;       // rd_* carries valid data this cycle
  logic           tail_first;  // first TAIL cycle: the rd_addr=N read
  logic           final_pend;  // s_N registered; top-word write next
  logic           issue;
  logic           wr_en_r;
  addr_t          wr_addr_r;
  logic [K-1:0]   wr_data_r;
  logic [K-1:0]   y_eff, m_eff;
  logic [SW-1:0]  sum;

  assign issue = (state == RUN) || tail_first;

  // Word N has no y/m contribution: s_N = a[N] + c_{N-1}.
  assign y_eff = (d_idx == LAST_A) ? '0 : bus.rd_y;
  assign m_eff = (d_idx == LAST_A) ? '0 : bus.rd_m;

  iddmm_mac_2x #(.K(K)) u_mac (
    .a (bus.rd_a),
    .x (x_r),
    .y (y_eff),
    .q (q_r),
    .m (m_eff),
    .c (carry_r),
    .s (sum)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (rd_addr_r == LAST_J) state_n = TAIL;
      TAIL:    if (final_pend) state_n = FLUSH;
      FLUSH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_r        <= '0;
      q_r        <= '0;
      carry_r    <= '0;
      rd_addr_r  <= '0;
      d_idx      <= '0;
      d_act      <= 1'b0;
      tail_first <= 1'b0;
      final_pend <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
    end else begin
      state      <= state_n;
      wr_en_r    <= 1'b0;
      final_pend <= 1'b0;
      tail_first <= (state == RUN) && (rd_addr_r == LAST_J);
      d_act      <= issue;
      d_idx      <= rd_addr_r;

      case (state)
        IDLE: begin
          if (bus.start) begin
            x_r       <= bus.x_i;
            q_r       <= bus.q;
            carry_r   <= '0;
            rd_addr_r <= '0;
          end
        end
        RUN:     rd_addr_r <= rd_addr_r + addr_t'(1);  // N-1 steps to N for TAIL
        default: ;
      endcase

      // Word j's sum lands here; its low half is A word j-1 (word 0 is
      // discarded, it is zero when q is correct).
      if (d_act) begin
        carry_r <= sum[SW-1:K];
        if (d_idx != '0) begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= d_idx - addr_t'(1);
          wr_data_r <= sum[K-1:0];
        end
        if (d_idx == LAST_A) final_pend <= 1'b1;
      end

      // Top word: the single carry bit left after s_N.
      if (final_pend) begin
        wr_en_r   <= 1'b1;
        wr_addr_r <= LAST_A;
        wr_data_r <= {{(K-1){1'b0}}, carry_r[0]};
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FLUSH);
  assign bus.rd_addr   = rd_addr_r;
  assign bus.wr_a_en   = wr_en_r;
  assign bus.wr_a_addr = wr_addr_r;
  assign bus.wr_a_data = wr_data_r;
  assign bus.dbg_state = state;

`ifdef IDDMM_A_CHECK_EN
  logic err_r;
  always_ff @(posedge clk) begin
    if (!rst_n) err_r <= 1'b0;
    else if (d_act && (d_idx == '0) && (sum[K-1:0] != '0)) err_r <= 1'b1;
  end
  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_iddmm_a_update.sv
// Bench for iddmm_a_update: a K=8/N=4 instance for directed cases and a
// K=128/N=32 instance for randomized back-to-back iterations checked against
// a big-integer reference. Honours IDDMM_A_CHECK_EN for the err expectation.
module tb_iddmm_a_update;
  import iddmm_pkg::*;

  localparam int KS = 8;
  localparam int NS = 4;
  localparam int KB = 128;
  localparam int NB = 32;
  localparam int BIG = KB * (NB + 2);
  typedef logic [BIG-1:0] big_t;

`ifdef IDDMM_A_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iddmm_a_if #(.K(KS), .N(NS)) s_if ();
  iddmm_a_if #(.K(KB), .N(NB)) b_if ();

  iddmm_a_update #(.K(KS), .N(NS)) u_small (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));
  iddmm_a_update #(.K(KB), .N(NB)) u_big   (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  // ---------------- RAM models (1-cycle read latency) ----------------
  logic [KS-1:0] ys [8];
  logic [KS-1:0] ms [8];
  logic [KS-1:0] as_ [8];
  logic [KB-1:0] yb [64];
  logic [KB-1:0] mb [64];
  logic [KB-1:0] ab [64];

  always @(posedge clk) begin
    s_if.rd_y <= ys[s_if.rd_addr];
    s_if.rd_m <= (s_if.rd_addr == 3'(NS)) ? '0 : ms[s_if.rd_addr];
    s_if.rd_a <= as_[s_if.rd_addr];
    b_if.rd_y <= yb[b_if.rd_addr];
    b_if.rd_m <= (b_if.rd_addr == 6'(NB)) ? '0 : mb[b_if.rd_addr];
    b_if.rd_a <= ab[b_if.rd_addr];
  end

  // ---------------- scoreboard ----------------
  logic [135:0] exp_s_q[$];
  logic [135:0] exp_b_q[$];
  int tests = 0;
  int fails = 0;
  int s_cyc, s_first, s_writes, s_unexp;
  int b_cyc, b_unexp;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KB-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // A' = floor((A + x*Y + q*M) / 2^K), whole-number arithmetic.
  function automatic big_t ref_update(big_t a, logic [KB-1:0] x, logic [KB-1:0] q,
                                      big_t y, big_t m);
    big_t xx, qq;
    xx = big_t'(x);
    qq = big_t'(q);
    return (a + xx * y + qq * m) >> KB;
  endfunction

  task automatic push_s(input int addr, input logic [KS-1:0] d);
    exp_s_q.push_back({8'(addr), 128'(d)});
  endtask

  // Advance to the next negedge and check any write on either DUT.
  task automatic tick();
    logic [135:0] e;
    @(negedge clk);
    s_cyc++;
    b_cyc++;
    if (s_if.wr_a_en === 1'b1) begin
      s_writes++;
      if (s_first < 0) s_first = s_cyc;
      if (exp_s_q.size() == 0) s_unexp++;
      else begin
        e = exp_s_q.pop_front();
        chk("s_wr_addr", 256'(s_if.wr_a_addr), 256'(e[135:128]));
        chk("s_wr_data", 256'(s_if.wr_a_data), 256'(e[127:0]));
      end
    end
    if (b_if.wr_a_en === 1'b1) begin
      if (exp_b_q.size() == 0) b_unexp++;
      else begin
        e = exp_b_q.pop_front();
        chk("b_wr_addr", 256'(b_if.wr_a_addr), 256'(e[135:128]));
        chk("b_wr_data", 256'(b_if.wr_a_data), 256'(e[127:0]));
      end
    end
  endtask

  // Start pulse sampled at edge 0; on return we are in cycle 1.
  task automatic kick_s(input logic [KS-1:0] x, input logic [KS-1:0] q);
    s_if.x_i = x;
    s_if.q = q;
    s_if.start = 1'b1;
    s_cyc = 0;
    s_first = -1;
    s_writes = 0;
    tick();
    s_if.start = 1'b0;
  endtask

  // Full small iteration over a fixed window; optional re-pulses of start in
  // cycle 2 (mid-run) and cycle 8 (the done cycle) must be ignored.
  task automatic run_small(input logic [KS-1:0] x, input logic [KS-1:0] q, input bit repulse);
    int busy_n, done_n, done_c;
    busy_n = 0;
    done_n = 0;
    done_c = -1;
    kick_s(x, q);
    for (int c = 0; c < 20; c++) begin
      if (s_if.busy === 1'b1) busy_n++;
      if (s_if.done === 1'b1) begin
        done_n++;
        if (done_c < 0) done_c = s_cyc;
      end
      s_if.start = repulse && (s_cyc == 2 || s_cyc == 8);
      tick();
    end
    s_if.start = 1'b0;
    chk("s_done_cycle", 256'(done_c), 256'(NS + 4));
    chk("s_first_wr_cycle", 256'(s_first), 256'(4));
    chk("s_busy_cycles", 256'(busy_n), 256'(NS + 4));
    chk("s_done_count", 256'(done_n), 256'(1));
    chk("s_write_count", 256'(s_writes), 256'(NS + 1));
    chk("s_queue_empty", 256'(exp_s_q.size()), 256'(0));
  endtask

  task automatic setup_ff();
    for (int j = 0; j < 8; j++) begin
      as_[j] = (j < NS) ? 8'hFF : 8'h00;
      ys[j]  = (j < NS) ? 8'hFF : 8'hAA;
      ms[j]  = 8'h00;
    end
  endtask

  task automatic setup_unit();
    for (int j = 0; j < 8; j++) begin
      as_[j] = 8'h00;
      ys[j]  = (j == 0) ? 8'h01 : ((j == NS) ? 8'hAA : 8'h00);
      ms[j]  = (j == 0) ? 8'h01 : 8'h00;
    end
  endtask

  big_t y_big, m_big, a_big, a_next;
  logic [KB-1:0] w, xb, qb;
  int b_busy, b_done_c, guard;

  initial begin
    s_if.start = 1'b0; s_if.x_i = '0; s_if.q = '0;
    b_if.start = 1'b0; b_if.x_i = '0; b_if.q = '0;
    s_cyc = 0; s_first = -1; s_writes = 0; s_unexp = 0;
    b_cyc = 0; b_unexp = 0;
    for (int j = 0; j < 8; j++) begin ys[j] = '0; ms[j] = '0; as_[j] = '0; end
    for (int j = 0; j < 64; j++) begin yb[j] = '0; mb[j] = '0; ab[j] = '0; end

    // Reset values
    repeat (3) tick();
    chk("rst_busy", 256'(s_if.busy), 256'(0));
    chk("rst_done", 256'(s_if.done), 256'(0));
    chk("rst_wr_en", 256'(s_if.wr_a_en), 256'(0));
    chk("rst_err", 256'(s_if.err), 256'(0));
    chk("rst_rd_addr", 256'(s_if.rd_addr), 256'(0));
    chk("rst_wr_addr", 256'(s_if.wr_a_addr), 256'(0));
    chk("rst_wr_data", 256'(s_if.wr_a_data), 256'(0));
    chk("rst_state", 256'(s_if.dbg_state), 256'(IDLE));
    chk("rst_b_busy", 256'(b_if.busy), 256'(0));
    chk("rst_b_wr_en", 256'(b_if.wr_a_en), 256'(0));
    rst_n = 1'b1;
    tick();

    // Unit operand, q cancels the low word of s_0
    setup_unit();
    push_s(0, 8'h01); push_s(1, 8'h00); push_s(2, 8'h00); push_s(3, 8'h00); push_s(4, 8'h00);
    run_small(8'h01, 8'hFF, 1'b0);
    chk("t1_err", 256'(s_if.err), 256'(0));

    // All-ones carry propagation
    setup_ff();
    push_s(0, 8'hFF); push_s(1, 8'hFF); push_s(2, 8'hFF); push_s(3, 8'hFF); push_s(4, 8'h00);
    run_small(8'hFF, 8'h00, 1'b0);

    // Same, with start re-pulsed mid-run and on the done cycle
    push_s(0, 8'hFF); push_s(1, 8'hFF); push_s(2, 8'hFF); push_s(3, 8'hFF); push_s(4, 8'h00);
    run_small(8'hFF, 8'h00, 1'b1);

    // Reset asserted in cycle 5 aborts the iteration
    push_s(0, 8'hFF); push_s(1, 8'hFF);
    kick_s(8'hFF, 8'h00);
    while (s_cyc < 5) tick();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_busy", 256'(s_if.busy), 256'(0));
      chk("abort_wr_en", 256'(s_if.wr_a_en), 256'(0));
      chk("abort_done", 256'(s_if.done), 256'(0));
    end
    rst_n = 1'b1;
    tick();
    chk("abort_queue", 256'(exp_s_q.size()), 256'(0));
    push_s(0, 8'hFF); push_s(1, 8'hFF); push_s(2, 8'hFF); push_s(3, 8'hFF); push_s(4, 8'h00);
    run_small(8'hFF, 8'h00, 1'b0);

    // Low word of s_0 nonzero (q=0): err only with the check built in
    setup_unit();
    for (int j = 0; j <= NS; j++) push_s(j, 8'h00);
    run_small(8'h01, 8'h00, 1'b0);
    chk("chk_err_set", 256'(s_if.err), 256'(EXP_ERR));
    push_s(0, 8'h01); push_s(1, 8'h00); push_s(2, 8'h00); push_s(3, 8'h00); push_s(4, 8'h00);
    run_small(8'h01, 8'hFF, 1'b0);
    chk("chk_err_sticky", 256'(s_if.err), 256'(EXP_ERR));
    chk("s_unexpected_writes", 256'(s_unexp), 256'(0));

    // Randomized K=128/N=32 back-to-back iterations vs big-integer model.
    // Top words of Y and M stay below 2^(K-1) so A remains below 2^(KN)+2.
    y_big = '0; m_big = '0; a_big = '0;
    for (int j = 0; j < NB; j++) begin
      w = rand_word(); if (j == NB - 1) w[KB-1] = 1'b0;
      yb[j] = w; y_big[j*KB +: KB] = w;
      w = rand_word(); if (j == NB - 1) w[KB-1] = 1'b0;
      mb[j] = w; m_big[j*KB +: KB] = w;
      a_big[j*KB +: KB] = rand_word();
    end
    yb[NB] = rand_word();
    mb[NB] = rand_word();
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j <= NB; j++) ab[j] = a_big[j*KB +: KB];
      xb = rand_word();
      qb = rand_word();
      a_next = ref_update(a_big, xb, qb, y_big, m_big);
      for (int j = 0; j <= NB; j++) exp_b_q.push_back({8'(j), a_next[j*KB +: KB]});
      b_if.x_i = xb;
      b_if.q = qb;
      b_if.start = 1'b1;
      b_cyc = 0;
      tick();
      b_if.start = 1'b0;
      b_busy = 0;
      b_done_c = -1;
      guard = 0;
      while (b_done_c < 0 && guard < 100) begin
        if (b_if.busy === 1'b1) b_busy++;
        if (b_if.done === 1'b1) b_done_c = b_cyc;
        else begin
          tick();
          guard++;
        end
      end
      chk("b_busy_cycles", 256'(b_busy), 256'(NB + 4));
      chk("b_done_cycle", 256'(b_done_c), 256'(NB + 4));
      chk("b_queue_empty", 256'(exp_b_q.size()), 256'(0));
      a_big = a_next;
      tick();  // next start lands in the cycle after done
    end
    repeat (5) tick();
    chk("b_unexpected_writes", 256'(b_unexp), 256'(0));
    chk("b_err", 256'(b_if.err), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
